sort_mem_host: RTL and testbench

- Memory responder and host front-end for the in-place quicksort engine.
- Owns the 2**AW x DW array that the sorter addresses.
- Loads the array from a host input stream, starts the sorter, serves its read/write memory port, then streams the sorted array back out.
- Sits between the host/stream fabric and the sorter. It answers the sorter's mem_addr/mem_wr_en/mem_wr_data/mem_rd_data interface.

---
 rtl/sort_mem_host.sv | 226 ++++++++++++++++++++++
 tb/tb_sort_mem_host.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_mem_host.sv
`default_nettype none
// ============================================================================
// Module      : sort_mem_host
// Description : Memory responder and host front-end for an in-place
//               quicksort engine. Owns the 2**AW x DW array the sorter
//               addresses. It loads the array from a host stream, starts
//               the sorter, serves the sorter's memory port while the sort
//               runs, and then streams the sorted array back out.
//
// Ports       :
//   clk, rst_n           system clock, asynchronous active-low reset
//   s_valid/s_ready      host load stream handshake
//   s_data/s_last        load element and end-of-load marker
//   m_valid/m_ready      sorted output stream handshake
//   m_data/m_last        sorted element and final-element marker
//   sort_start           level held high while the sorter should run
//   sort_left/right      sort bounds (0 .. count-1)
//   sort_done            one-cycle completion pulse from the sorter
//   mem_addr/mem_wr_en/mem_wr_data/mem_rd_data
//                        sorter memory port, 1-cycle registered read
//   busy                 high whenever not accepting a load
//   sort_cycles          saturating cycle count of the last sort
//
// The sorter's active-high reset is expected to be driven from ~rst_n.
//
// Revision    : 1.0 - initial release
// ============================================================================
module sort_mem_host #(
    parameter int AW = 6,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    // host load stream
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    input  logic          s_last,
    // host output stream
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_last,
    // sorter control
    output logic          sort_start,
    output logic [AW-1:0] sort_left,
    output logic [AW-1:0] sort_right,
    input  logic          sort_done,
    // sorter memory port
    input  logic          mem_wr_en,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_wr_data,
    output logic [DW-1:0] mem_rd_data,
    // status
    output logic          busy,
    output logic [15:0]   sort_cycles
);

    localparam int DEPTH = 1 << AW;

    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_SORT  = 2'd1;
    localparam logic [1:0] ST_RD    = 2'd2;
    localparam logic [1:0] ST_VALID = 2'd3;

    // cnt is one bit wider than an address so a completely full array
    // (2**AW elements) is representable.
    localparam logic [AW:0]   CNT_FULL = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]   CNT_LAST = {1'b0, {AW{1'b1}}};
    localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

    logic [1:0]    state_q,       state_d;
    logic [AW:0]   cnt_q,         cnt_d;
    logic [AW-1:0] rd_ptr_q,      rd_ptr_d;
    logic          sort_start_q,  sort_start_d;
    logic [AW-1:0] sort_right_q,  sort_right_d;
    logic [15:0]   sort_cycles_q, sort_cycles_d;
    logic [DW-1:0] rd_data_q,     rd_data_d;

    logic [DW-1:0] mem_q [DEPTH];

    logic          load_beat;
    logic          last_out;
    logic [AW:0]   cnt_minus1;
    logic [AW-1:0] raddr;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          we;

    // ------------------------------------------------------------------
    // Stream-side handshakes
    // ------------------------------------------------------------------
    assign s_ready    = (state_q == ST_LOAD) && (cnt_q < CNT_FULL);
    assign load_beat  = s_valid && s_ready;
    assign cnt_minus1 = cnt_q - CNT_ONE;
    assign last_out   = ({1'b0, rd_ptr_q} == cnt_minus1);

    assign m_valid     = (state_q == ST_VALID);
    assign m_last      = (state_q == ST_VALID) && last_out;
    assign m_data      = rd_data_q;
    assign mem_rd_data = rd_data_q;

    assign sort_start  = sort_start_q;
    assign sort_left   = '0;
    assign sort_right  = sort_right_q;
    assign sort_cycles = sort_cycles_q;
    assign busy        = (state_q != ST_LOAD);

    // ------------------------------------------------------------------
    // Control FSM and counters
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rd_ptr_d      = rd_ptr_q;
        sort_start_d  = sort_start_q;
        sort_right_d  = sort_right_q;
        sort_cycles_d = sort_cycles_q;

        case (state_q)
            ST_LOAD: begin
                if (load_beat) begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (s_last || (cnt_q == CNT_LAST)) begin
                        state_d       = ST_SORT;
                        // (cnt+1)-1: the index of the beat just written
                        sort_right_d  = cnt_q[AW-1:0];
                        sort_start_d  = 1'b1;
                        sort_cycles_d = 16'd0;
                    end
                end
            end
            ST_SORT: begin
                if (sort_cycles_q != 16'hFFFF) begin
                    sort_cycles_d = sort_cycles_q + 16'd1;
                end
                if (sort_done) begin
                    sort_start_d = 1'b0;
                    rd_ptr_d     = '0;
                    state_d      = ST_RD;
                end
            end
            ST_RD: begin
                // rd_ptr is on the read address this cycle; q is valid next
                state_d = ST_VALID;
            end
            ST_VALID: begin
                if (m_ready) begin
                    if (last_out) begin
                        state_d = ST_LOAD;
                        cnt_d   = '0;
                    end else begin
                        rd_ptr_d = rd_ptr_q + PTR_ONE;
                        state_d  = ST_RD;
                    end
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Array address / write mux
    // ------------------------------------------------------------------
    always_comb begin
        raddr = rd_ptr_q;
        waddr = cnt_q[AW-1:0];
        wdata = s_data;
        we    = 1'b0;
        case (state_q)
            ST_LOAD: begin
                raddr = cnt_q[AW-1:0];
                waddr = cnt_q[AW-1:0];
                wdata = s_data;
                we    = load_beat;
            end
            ST_SORT: begin
                raddr = mem_addr;
                waddr = mem_addr;
                wdata = mem_wr_data;
                we    = mem_wr_en;
            end
            default: begin
                // output phase: address held on rd_ptr so q stays stable
                raddr = rd_ptr_q;
                we    = 1'b0;
            end
        endcase
    end

    // Read-before-write: a same-cycle write to the read address returns
    // the old contents, which the sorter's pivot/left/right loads rely on.
    assign rd_data_d = mem_q[raddr];

    // Array contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_LOAD;
            cnt_q         <= '0;
            rd_ptr_q      <= '0;
            sort_start_q  <= 1'b0;
            sort_right_q  <= '0;
            sort_cycles_q <= 16'd0;
            rd_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rd_ptr_q      <= rd_ptr_d;
            sort_start_q  <= sort_start_d;
            sort_right_q  <= sort_right_d;
            sort_cycles_q <= sort_cycles_d;
            rd_data_q     <= rd_data_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sort_mem_host.sv
`default_nettype none
// ============================================================================
// Module      : tb_sort_mem_host
// Description : Self-checking bench for sort_mem_host. A behavioural sorter
//               works the memory port; expected output beats are queued when
//               a load is driven and popped as the DUT streams them out.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sort_mem_host;

    logic       clk;
    logic       rst_n;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       s_last;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_last;
    logic       sort_start;
    logic [5:0] sort_left;
    logic [5:0] sort_right;
    logic       sort_done;
    logic       mem_wr_en;
    logic [5:0] mem_addr;
    logic [7:0] mem_wr_data;
    logic [7:0] mem_rd_data;
    logic       busy;
    logic [15:0] sort_cycles;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] stim [64];
    logic [7:0] work [64];

    sort_mem_host #(.AW(6), .DW(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_last      (s_last),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_last      (m_last),
        .sort_start  (sort_start),
        .sort_left   (sort_left),
        .sort_right  (sort_right),
        .sort_done   (sort_done),
        .mem_wr_en   (mem_wr_en),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data),
        .busy        (busy),
        .sort_cycles (sort_cycles)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic sort_work(input int n);
        logic [7:0] key;
        int j;
        for (int i = 1; i < n; i++) begin
            key = work[i];
            j = i - 1;
            while (j >= 0 && work[j] > key) begin
                work[j+1] = work[j];
                j--;
            end
            work[j+1] = key;
        end
    endtask

    task automatic push_expected(input int n, input bit sorted);
        for (int i = 0; i < n; i++) work[i] = stim[i];
        if (sorted) sort_work(n);
        for (int i = 0; i < n; i++) exp_q.push_back(work[i]);
    endtask

    task automatic load(input int n, input bit use_last);
        logic [5:0] exp_r;
        exp_r = 6'(n - 1);
        for (int i = 0; i < n; i++) begin
            n_checks++;
            if (s_ready !== 1'b1) begin
                n_errors++;
                $display("FAIL load_ready beat %0d: s_ready=%b required 1", i, s_ready);
            end
            s_valid = 1'b1;
            s_data  = stim[i];
            s_last  = use_last && (i == n - 1);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        n_checks++;
        if ({s_ready, busy, sort_start} !== 3'b011) begin
            n_errors++;
            $display("FAIL load_enter_sort: s_ready/busy/sort_start=%b required 011",
                     {s_ready, busy, sort_start});
        end
        n_checks++;
        if (sort_right !== exp_r || sort_left !== 6'd0 || sort_cycles !== 16'd0) begin
            n_errors++;
            $display("FAIL load_bounds: left=%0d right=%0d cycles=%0d required 0 %0d 0",
                     sort_left, sort_right, sort_cycles, exp_r);
        end
    endtask

    // Behavioural sorter: reads the range, sorts, writes back, pulses done.
    task automatic run_sorter(input bit do_sort, input int pre_edges);
        int n;
        int edges;
        edges = pre_edges;
        n = int'(sort_right) + 1;
        if (do_sort) begin
            for (int i = 0; i < n; i++) begin
                mem_addr = 6'(i);
                @(posedge clk); #1;
                edges++;
                work[i] = mem_rd_data;
            end
            sort_work(n);
            for (int i = 0; i < n; i++) begin
                mem_addr    = 6'(i);
                mem_wr_en   = 1'b1;
                mem_wr_data = work[i];
                @(posedge clk); #1;
                edges++;
            end
            mem_wr_en = 1'b0;
        end
        n_checks++;
        if (sort_start !== 1'b1) begin
            n_errors++;
            $display("FAIL sort_start_held: sort_start=%b required 1", sort_start);
        end
        sort_done = 1'b1;
        @(posedge clk); #1;
        edges++;
        sort_done = 1'b0;
        n_checks++;
        if ({sort_start, busy, m_valid} !== 3'b010) begin
            n_errors++;
            $display("FAIL after_done: sort_start/busy/m_valid=%b required 010",
                     {sort_start, busy, m_valid});
        end
        n_checks++;
        if (sort_cycles !== 16'(edges)) begin
            n_errors++;
            $display("FAIL sort_cycles: got %0d required %0d", sort_cycles, edges);
        end
    endtask

    task automatic collect(input int n);
        logic [7:0] e;
        int waitc;
        m_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            waitc = 0;
            while (m_valid !== 1'b1 && waitc < 20) begin
                @(posedge clk); #1;
                waitc++;
            end
            n_checks++;
            if (m_valid !== 1'b1 || exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL collect_timeout beat %0d: m_valid=%b required 1 (queued %0d)",
                         i, m_valid, exp_q.size());
                m_ready = 1'b0;
                return;
            end
            e = exp_q.pop_front();
            n_checks++;
            if (m_data !== e) begin
                n_errors++;
                $display("FAIL out_data beat %0d: got %h required %h", i, m_data, e);
            end
            n_checks++;
            if (m_last !== (i == n - 1)) begin
                n_errors++;
                $display("FAIL out_last beat %0d: got %b required %b", i, m_last, (i == n - 1));
            end
            @(posedge clk); #1;
        end
        m_ready = 1'b0;
        n_checks++;
        if ({busy, s_ready, m_valid} !== 3'b010) begin
            n_errors++;
            $display("FAIL back_to_load: busy/s_ready/m_valid=%b required 010",
                     {busy, s_ready, m_valid});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
        m_ready = 1'b0; sort_done = 1'b0;
        mem_wr_en = 1'b0; mem_addr = 6'd0; mem_wr_data = 8'h00;
        #12;
        n_checks++;
        if ({sort_start, m_valid, m_last, busy} !== 4'b0000 ||
            sort_right !== 6'd0 || sort_cycles !== 16'd0 ||
            mem_rd_data !== 8'h00 || m_data !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_outputs: start/mv/ml/busy=%b right=%0d cyc=%0d rd=%h md=%h required all 0",
                     {sort_start, m_valid, m_last, busy}, sort_right, sort_cycles, mem_rd_data, m_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (s_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_s_ready: got %b required 1", s_ready);
        end
    endtask

    task automatic test_sort5();
        stim[0] = 8'd9; stim[1] = 8'd3; stim[2] = 8'd7; stim[3] = 8'd1; stim[4] = 8'd5;
        push_expected(5, 1'b1);
        load(5, 1'b1);
        run_sorter(1'b1, 0);
        collect(5);
    endtask

    task automatic test_single();
        stim[0] = 8'h2A;
        push_expected(1, 1'b1);
        load(1, 1'b1);
        run_sorter(1'b0, 0);
        collect(1);
    endtask

    task automatic test_full();
        for (int i = 0; i < 64; i++) stim[i] = 8'($urandom_range(0, 255));
        push_expected(64, 1'b1);
        load(64, 1'b0);
        run_sorter(1'b1, 0);
        collect(64);
    endtask

    task automatic test_raw();
        for (int i = 0; i < 8; i++) stim[i] = 8'(i * 16 + 3);
        push_expected(8, 1'b0);
        exp_q[exp_q.size() - 3] = 8'h11;   // element 5 of 8 is overwritten
        load(8, 1'b1);
        mem_addr    = 6'd5;
        mem_wr_en   = 1'b1;
        mem_wr_data = 8'h11;
        @(posedge clk); #1;
        mem_wr_en = 1'b0;
        n_checks++;
        if (mem_rd_data !== 8'h53) begin
            n_errors++;
            $display("FAIL raw_old_data: got %h required 53", mem_rd_data);
        end
        @(posedge clk); #1;
        n_checks++;
        if (mem_rd_data !== 8'h11) begin
            n_errors++;
            $display("FAIL raw_new_data: got %h required 11", mem_rd_data);
        end
        run_sorter(1'b0, 2);
        collect(8);
    endtask

    task automatic test_backpressure();
        logic [7:0] e;
        int waitc;
        stim[0] = 8'd40; stim[1] = 8'd20; stim[2] = 8'd30;
        push_expected(3, 1'b1);
        load(3, 1'b1);
        run_sorter(1'b1, 0);
        m_ready = 1'b0;
        waitc = 0;
        while (m_valid !== 1'b1 && waitc < 20) begin
            @(posedge clk); #1;
            waitc++;
        end
        e = exp_q[0];
        // stray load beats and done pulses must be ignored while stalled
        s_valid = 1'b1; s_data = 8'hFF; sort_done = 1'b1;
        for (int c = 0; c < 10; c++) begin
            n_checks++;
            if ({m_valid, m_last, s_ready} !== 3'b100 || m_data !== e) begin
                n_errors++;
                $display("FAIL stall_hold cycle %0d: mv/ml/sr=%b data=%h required 100 %h",
                         c, {m_valid, m_last, s_ready}, m_data, e);
            end
            @(posedge clk); #1;
        end
        s_valid = 1'b0; sort_done = 1'b0;
        collect(3);
    endtask

    task automatic test_reset_mid_sort();
        int waitc;
        for (int i = 0; i < 6; i++) stim[i] = 8'(60 - i * 7);
        load(6, 1'b1);
        waitc = 0;
        while (sort_cycles !== 16'd37 && waitc < 100) begin
            @(posedge clk); #1;
            waitc++;
        end
        n_checks++;
        if (sort_cycles !== 16'd37) begin
            n_errors++;
            $display("FAIL mid_sort_count: got %0d required 37", sort_cycles);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({sort_start, busy} !== 2'b00 || sort_cycles !== 16'd0) begin
            n_errors++;
            $display("FAIL async_reset: start/busy=%b cycles=%0d required 00 0",
                     {sort_start, busy}, sort_cycles);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({s_ready, busy} !== 2'b10) begin
            n_errors++;
            $display("FAIL post_reset: s_ready/busy=%b required 10", {s_ready, busy});
        end
        stim[0] = 8'd4; stim[1] = 8'd2;
        push_expected(2, 1'b1);
        load(2, 1'b1);
        run_sorter(1'b1, 0);
        collect(2);
    endtask

    initial begin
        test_reset();
        test_sort5();
        test_single();
        test_full();
        test_raw();
        test_backpressure();
        test_reset_mid_sort();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL leftover_expected: %0d beats never produced, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
